// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one down-counter between two delay requesters.
// Grants are issued from IDLE or DONE; done strobes are registered alongside the DONE entry.
module counter_sched #(
  parameter int unsigned WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] len0,
  input  logic [WIDTH-1:0] len1,
  input  logic             abort,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             busy,
  output logic             owner,
  output logic [WIDTH-1:0] q
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic             last;
  logic             can_grant;
  logic             any_req;
  logic             win;
  logic [WIDTH-1:0] win_len;

  always_comb begin
    can_grant = reset && (state == IDLE || state == DONE);
    any_req   = req0 | req1;
    // On a tie the requester that did not win last time goes next.
    win       = (req0 && req1) ? ~last : ~req0;
    win_len   = win ? len1 : len0;
    gnt0      = can_grant && any_req && !win;
    gnt1      = can_grant && any_req && win;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      q     <= '0;
      owner <= 1'b0;
      last  <= 1'b1;
      done0 <= 1'b0;
      done1 <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (gnt0 || gnt1) begin
            owner <= win;
            last  <= win;
            q     <= win_len;
            if (win_len != '0) begin
              state <= RUN;
            end else begin
              state <= DONE;
              done0 <= ~win;
              done1 <= win;
            end
          end else begin
            state <= IDLE;
            q     <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            q     <= '0;
          end else if (q == WIDTH'(1) || q == '0) begin
            state <= DONE;
            q     <= '0;
            done0 <= ~owner;
            done1 <= owner;
          end else begin
            q <= q - WIDTH'(1);
          end
        end
        default: begin
          state <= IDLE;
          q     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_sched.sv
// Directed scenarios plus randomized traffic for counter_sched, checked every cycle
// against a transaction-level model (delay in flight, owner, cycle at which it expires).
module tb_counter_sched;
  localparam int unsigned W = 7;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0, req1, abort;
  logic [W-1:0] len0, len1;
  logic         gnt0, gnt1, done0, done1, busy, owner;
  logic [W-1:0] q;

  counter_sched #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .len0(len0), .len1(len1), .abort(abort),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .busy(busy), .owner(owner), .q(q)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  bit m_active;
  bit m_owner;
  bit m_last;
  int m_done_cyc;
  int last_gnt;
  int gnt_log[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_owner  = 1'b0;
    m_last   = 1'b1;
  endtask

  function automatic int rand_len();
    int s;
    s = int'($urandom % 16);
    if (s == 0) return 0;
    if (s == 1) return 127;
    if (s == 2) return int'($urandom_range(8, 127));
    return int'($urandom_range(1, 6));
  endfunction

  // One clock cycle: entered and left at posedge+1.
  task automatic step(input bit r0, input int l0, input bit r1, input int l1, input bit ab);
    bit elig, w, eg0, eg1, in_run, exp_done;
    int c, eq;
    c = cyc;
    req0 = r0; len0 = W'(l0); req1 = r1; len1 = W'(l1); abort = ab;
    #4;
    in_run   = m_active && c < m_done_cyc;
    elig     = !m_active || c == m_done_cyc;
    w        = (r0 && r1) ? !m_last : r1;
    eg0      = elig && (r0 || r1) && !w;
    eg1      = elig && (r0 || r1) && w;
    eq       = in_run ? m_done_cyc - c : 0;
    exp_done = m_active && c == m_done_cyc;
    check("gnt0", 32'(gnt0), 32'(eg0));
    check("gnt1", 32'(gnt1), 32'(eg1));
    check("q", 32'(q), 32'(eq));
    check("busy", 32'(busy), 32'(m_active));
    check("done0", 32'(done0), 32'(exp_done && !m_owner));
    check("done1", 32'(done1), 32'(exp_done && m_owner));
    check("owner", 32'(owner), 32'(m_owner));
    last_gnt = eg0 ? 0 : (eg1 ? 1 : -1);
    if (gnt0) gnt_log.push_back(0);
    if (gnt1) gnt_log.push_back(1);
    @(posedge clk); #1;
    cyc++;
    if (eg0 || eg1) begin
      m_active   = 1'b1;
      m_owner    = w;
      m_last     = w;
      m_done_cyc = c + 1 + (w ? l1 : l0);
    end else if (in_run && ab) begin
      m_active = 1'b0;
    end else if (exp_done) begin
      m_active = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  // Asserts reset between edges with both requests high, then releases at posedge+1.
  task automatic async_reset_mid();
    req0 = 1'b1; req1 = 1'b1; abort = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("rst_q", 32'(q), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_owner", 32'(owner), 0);
    check("rst_done", 32'({done1, done0}), 0);
    check("rst_gnt", 32'({gnt1, gnt0}), 0);
    model_reset();
    @(posedge clk); #1;
    check("rst_hold_gnt", 32'({gnt1, gnt0}), 0);
    check("rst_hold_done", 32'({done1, done0}), 0);
    reset = 1'b1;
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit r0, r1;
    int l0, l1;
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0; abort = 1'b0; len0 = '0; len1 = '0;
    model_reset();
    #2;
    check("init_q", 32'(q), 0);
    check("init_busy", 32'(busy), 0);
    check("init_owner", 32'(owner), 0);
    check("init_done", 32'({done1, done0}), 0);
    req0 = 1'b1;
    #1 check("init_gnt_forced_low", 32'({gnt1, gnt0}), 0);
    req0 = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Single delay of 5.
    step(1, 5, 0, 0, 0);
    idle(8);

    // Fresh reset so the first tie goes to req0, then hold both requests.
    async_reset_mid();
    gnt_log.delete();
    for (int i = 0; i < 15; i++) step(1, 2, 1, 3, 0);
    check("rr_count", 32'(gnt_log.size()), 5);
    check("rr_0", 32'(gnt_log[0]), 0);
    check("rr_1", 32'(gnt_log[1]), 1);
    check("rr_2", 32'(gnt_log[2]), 0);
    check("rr_3", 32'(gnt_log[3]), 1);
    idle(6);

    // Zero length.
    step(0, 0, 1, 0, 0);
    idle(3);

    // Abort at T+4 with req1 pending; req1 granted at T+5.
    step(1, 10, 0, 0, 0);
    idle(3);
    step(0, 0, 1, 4, 1);
    step(0, 0, 1, 4, 0);
    idle(7);

    // Asynchronous reset at T+7 of a 20-cycle delay; then a tie goes to req0.
    step(1, 20, 0, 0, 0);
    idle(6);
    async_reset_mid();
    gnt_log.delete();
    step(1, 1, 1, 1, 0);
    check("post_reset_tie", 32'(gnt_log.size() > 0 ? gnt_log[0] : -1), 0);
    idle(4);

    // Maximum length.
    step(1, 127, 0, 0, 0);
    idle(130);

    // Randomized traffic following the requester protocol.
    r0 = 1'b0; r1 = 1'b0; l0 = 0; l1 = 0;
    for (int i = 0; i < 3000; i++) begin
      step(r0, l0, r1, l1, ($urandom % 12) == 0);
      if (last_gnt == 0) begin
        r0 = ($urandom % 3) == 0; l0 = rand_len();
      end else if (!r0 && ($urandom % 4) == 0) begin
        r0 = 1'b1; l0 = rand_len();
      end
      if (last_gnt == 1) begin
        r1 = ($urandom % 3) == 0; l1 = rand_len();
      end else if (!r1 && ($urandom % 4) == 0) begin
        r1 = 1'b1; l1 = rand_len();
      end
      if (($urandom % 600) == 0) async_reset_mid();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
